// File: rtl/qlearn_update_engine.sv
// Q-learning update engine: Q[s,a] <= (1-a)Q + a*r + a*g*Qmax[s'], 4-cycle accept->write-back, o_ready drops on state hazards.
// Tables are zeroed by a clear walk after reset; define QL_FWD_EN to forward S4 into S2 and shrink the stall window to S1..S3.
module qlearn_update_engine #(
  parameter  int N_STATES  = 64,
  parameter  int N_ACTIONS = 4,
  parameter  int DATA_W    = 16,
  parameter  int FRAC_W    = 8,
  localparam int S_W       = $clog2(N_STATES),
  localparam int A_W       = $clog2(N_ACTIONS)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [S_W-1:0]    i_state,
  input  logic [A_W-1:0]    i_action,
  input  logic [S_W-1:0]    i_next_state,
  input  logic [DATA_W-1:0] i_reward,
  input  logic [FRAC_W:0]   i_alpha,
  input  logic [FRAC_W:0]   i_gamma,
  output logic              o_upd_valid,
  output logic [S_W-1:0]    o_upd_state,
  output logic [A_W-1:0]    o_upd_action,
  output logic [DATA_W-1:0] o_upd_q,
  output logic              o_upd_qmax_wr,
  output logic              o_busy,
  input  logic [S_W-1:0]    i_rd_state,
  input  logic [A_W-1:0]    i_rd_action,
  output logic [DATA_W-1:0] o_rd_q,
  output logic [DATA_W-1:0] o_rd_qmax
);
  localparam int Q_D  = N_STATES * N_ACTIONS;
  localparam int QA_W = $clog2(Q_D);
  localparam int PA_W = 2 * FRAC_W + 2;
  localparam int PQ_W = DATA_W + FRAC_W + 1;
  localparam logic [FRAC_W:0] ONE = {1'b1, {FRAC_W{1'b0}}};
`ifdef QL_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

  typedef struct packed {
    logic              vld;
    logic [S_W-1:0]    st;
    logic [A_W-1:0]    act;
    logic [S_W-1:0]    nst;
    logic [DATA_W-1:0] rew;
    logic [FRAC_W:0]   alpha;
    logic [FRAC_W:0]   gamma;
  } s1_t;

  typedef struct packed {
    logic              vld;
    logic [S_W-1:0]    st;
    logic [A_W-1:0]    act;
    logic [DATA_W-1:0] rew;
    logic [FRAC_W:0]   alpha;
    logic [FRAC_W:0]   oma;
    logic [FRAC_W:0]   ag;
    logic [DATA_W-1:0] q;
    logic [DATA_W-1:0] qmax_s;
    logic [DATA_W-1:0] qmax_ns;
  } s2_t;

  typedef struct packed {
    logic              vld;
    logic [S_W-1:0]    st;
    logic [A_W-1:0]    act;
    logic [DATA_W-1:0] qmax_s;
    logic [DATA_W-1:0] t1;
    logic [DATA_W-1:0] t2;
    logic [DATA_W-1:0] t3;
  } s3_t;

  typedef struct packed {
    logic              vld;
    logic [S_W-1:0]    st;
    logic [A_W-1:0]    act;
    logic [DATA_W-1:0] sum;
    logic              qmax_wr;
  } s4_t;

  function automatic logic [QA_W-1:0] q_addr(input logic [S_W-1:0] st, input logic [A_W-1:0] act);
    return QA_W'(st) * QA_W'(N_ACTIONS) + QA_W'(act);
  endfunction

  logic [DATA_W-1:0] q_mem    [Q_D];
  logic [DATA_W-1:0] qmax_mem [N_STATES];

  state_t            state_q;
  logic [QA_W-1:0]   clr_addr_q;
  logic              busy_q;
  s1_t               s1_d, s1_q;
  s2_t               s2_d, s2_q;
  s3_t               s3_d, s3_q;
  s4_t               s4_d, s4_q;
  logic [DATA_W+1:0] sum_w;
  logic              hazard, accept;
  logic              q_we, m_we;
  logic [QA_W-1:0]   q_wa;
  logic [S_W-1:0]    m_wa;
  logic [DATA_W-1:0] q_wd, m_wd;
  logic [DATA_W-1:0] rd_q_d, rd_q_q, rd_max_d, rd_max_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
      busy_q     <= 1'b1;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          if (clr_addr_q == QA_W'(Q_D - 1)) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b0;
          end else begin
            clr_addr_q <= clr_addr_q + QA_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // A new transition may not touch a state whose write-back is still in flight.
  always_comb begin
    hazard = 1'b0;
    if (s1_q.vld && (s1_q.st == i_state || s1_q.st == i_next_state)) hazard = 1'b1;
    if (s2_q.vld && (s2_q.st == i_state || s2_q.st == i_next_state)) hazard = 1'b1;
    if (s3_q.vld && (s3_q.st == i_state || s3_q.st == i_next_state)) hazard = 1'b1;
    if (!FWD && s4_q.vld && (s4_q.st == i_state || s4_q.st == i_next_state)) hazard = 1'b1;
  end

  assign o_ready = (state_q == ST_RUN) && !hazard;
  assign accept  = i_valid && o_ready;

  always_comb begin
    s1_d       = '0;
    s1_d.vld   = accept;
    s1_d.st    = i_state;
    s1_d.act   = i_action;
    s1_d.nst   = i_next_state;
    s1_d.rew   = i_reward;
    s1_d.alpha = (i_alpha > ONE) ? ONE : i_alpha;
    s1_d.gamma = (i_gamma > ONE) ? ONE : i_gamma;
  end

  always_comb begin
    s2_d         = '0;
    s2_d.vld     = s1_q.vld;
    s2_d.st      = s1_q.st;
    s2_d.act     = s1_q.act;
    s2_d.rew     = s1_q.rew;
    s2_d.alpha   = s1_q.alpha;
    s2_d.oma     = ONE - s1_q.alpha;
    s2_d.ag      = (FRAC_W + 1)'((PA_W'(s1_q.alpha) * PA_W'(s1_q.gamma)) >> FRAC_W);
    s2_d.q       = q_mem[q_addr(s1_q.st, s1_q.act)];
    s2_d.qmax_s  = qmax_mem[s1_q.st];
    s2_d.qmax_ns = qmax_mem[s1_q.nst];
    if (FWD && s4_q.vld) begin
      if (q_addr(s4_q.st, s4_q.act) == q_addr(s1_q.st, s1_q.act)) s2_d.q = s4_q.sum;
      if (s4_q.qmax_wr && s4_q.st == s1_q.st)  s2_d.qmax_s  = s4_q.sum;
      if (s4_q.qmax_wr && s4_q.st == s1_q.nst) s2_d.qmax_ns = s4_q.sum;
    end
  end

  always_comb begin
    s3_d        = '0;
    s3_d.vld    = s2_q.vld;
    s3_d.st     = s2_q.st;
    s3_d.act    = s2_q.act;
    s3_d.qmax_s = s2_q.qmax_s;
    s3_d.t1     = DATA_W'((PQ_W'(s2_q.oma)   * PQ_W'(s2_q.q))       >> FRAC_W);
    s3_d.t2     = DATA_W'((PQ_W'(s2_q.alpha) * PQ_W'(s2_q.rew))     >> FRAC_W);
    s3_d.t3     = DATA_W'((PQ_W'(s2_q.ag)    * PQ_W'(s2_q.qmax_ns)) >> FRAC_W);
  end

  always_comb begin
    sum_w        = (DATA_W + 2)'(s3_q.t1) + (DATA_W + 2)'(s3_q.t2) + (DATA_W + 2)'(s3_q.t3);
    s4_d         = '0;
    s4_d.vld     = s3_q.vld;
    s4_d.st      = s3_q.st;
    s4_d.act     = s3_q.act;
    s4_d.sum     = (sum_w[DATA_W+1:DATA_W] != 2'b00) ? {DATA_W{1'b1}} : sum_w[DATA_W-1:0];
    s4_d.qmax_wr = s3_q.vld && (s4_d.sum > s3_q.qmax_s);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
      s4_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
      s4_q <= s4_d;
    end
  end

  // Single write port per table: clear walk owns it until RUN, then S4 write-back.
  always_comb begin
    q_we = 1'b0;
    q_wa = '0;
    q_wd = '0;
    m_we = 1'b0;
    m_wa = '0;
    m_wd = '0;
    if (state_q == ST_CLEAR) begin
      q_we = 1'b1;
      q_wa = clr_addr_q;
      m_we = (clr_addr_q < QA_W'(N_STATES));
      m_wa = clr_addr_q[S_W-1:0];
    end else if (s4_q.vld) begin
      q_we = 1'b1;
      q_wa = q_addr(s4_q.st, s4_q.act);
      q_wd = s4_q.sum;
      m_we = s4_q.qmax_wr;
      m_wa = s4_q.st;
      m_wd = s4_q.sum;
    end
  end

  always_ff @(posedge i_clk) begin
    if (q_we) q_mem[q_wa] <= q_wd;
    if (m_we) qmax_mem[m_wa] <= m_wd;
  end

  always_comb begin
    rd_q_d   = q_mem[q_addr(i_rd_state, i_rd_action)];
    rd_max_d = qmax_mem[i_rd_state];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_q_q   <= '0;
      rd_max_q <= '0;
    end else begin
      rd_q_q   <= rd_q_d;
      rd_max_q <= rd_max_d;
    end
  end

  assign o_rd_q        = rd_q_q;
  assign o_rd_qmax     = rd_max_q;
  assign o_busy        = busy_q;
  assign o_upd_valid   = s4_q.vld;
  assign o_upd_state   = s4_q.st;
  assign o_upd_action  = s4_q.act;
  assign o_upd_q       = s4_q.sum;
  assign o_upd_qmax_wr = s4_q.qmax_wr;

endmodule

// File: tb/tb_qlearn_update_engine.sv
// Directed bench for qlearn_update_engine: clear walk, arithmetic, saturation, clamping, hazard stalls, streaming, mid-stream reset.
module tb_qlearn_update_engine;
  localparam int S_W    = 6;
  localparam int A_W    = 2;
  localparam int DATA_W = 16;
  localparam int FRAC_W = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              i_valid = 1'b0;
  logic              o_ready;
  logic [S_W-1:0]    i_state = '0;
  logic [A_W-1:0]    i_action = '0;
  logic [S_W-1:0]    i_next_state = '0;
  logic [DATA_W-1:0] i_reward = '0;
  logic [FRAC_W:0]   i_alpha = '0;
  logic [FRAC_W:0]   i_gamma = '0;
  logic              o_upd_valid;
  logic [S_W-1:0]    o_upd_state;
  logic [A_W-1:0]    o_upd_action;
  logic [DATA_W-1:0] o_upd_q;
  logic              o_upd_qmax_wr;
  logic              o_busy;
  logic [S_W-1:0]    i_rd_state = '0;
  logic [A_W-1:0]    i_rd_action = '0;
  logic [DATA_W-1:0] o_rd_q;
  logic [DATA_W-1:0] o_rd_qmax;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  qlearn_update_engine dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_state(i_state), .i_action(i_action), .i_next_state(i_next_state),
    .i_reward(i_reward), .i_alpha(i_alpha), .i_gamma(i_gamma),
    .o_upd_valid(o_upd_valid), .o_upd_state(o_upd_state), .o_upd_action(o_upd_action),
    .o_upd_q(o_upd_q), .o_upd_qmax_wr(o_upd_qmax_wr), .o_busy(o_busy),
    .i_rd_state(i_rd_state), .i_rd_action(i_rd_action), .o_rd_q(o_rd_q), .o_rd_qmax(o_rd_qmax)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one transition and returns once it has been transferred; stalls counts cycles with o_ready low.
  task automatic send(input int s, input int a, input int ns, input int r, input int al, input int ga,
                      output int stalls);
    stalls       = 0;
    i_state      = S_W'(s);
    i_action     = A_W'(a);
    i_next_state = S_W'(ns);
    i_reward     = DATA_W'(r);
    i_alpha      = (FRAC_W + 1)'(al);
    i_gamma      = (FRAC_W + 1)'(ga);
    i_valid      = 1'b1;
    #1;
    while (!o_ready && stalls < 100) begin
      tick();
      stalls++;
    end
    check("accept_bound", 32'(stalls < 100), 1);
    tick();
    i_valid = 1'b0;
  endtask

  task automatic rd(input int s, input int a, output int q, output int m);
    i_rd_state  = S_W'(s);
    i_rd_action = A_W'(a);
    tick();
    tick();
    q = int'(o_rd_q);
    m = int'(o_rd_qmax);
  endtask

  initial begin
    int st0, st1, q, m, cnt, upd_cnt, upd_sum, first, last, ready_low, cyc;

    repeat (3) tick();
    check("rst_busy", o_busy, 1);
    check("rst_ready", o_ready, 0);
    check("rst_upd_valid", o_upd_valid, 0);
    check("rst_qmax_wr", o_upd_qmax_wr, 0);
    check("rst_rd_q", o_rd_q, 0);

    rst_n = 1'b1;
    cnt = 0;
    while (o_busy && cnt < 1000) begin
      tick();
      cnt++;
    end
    check("clear_cycles", cnt, 256);
    check("ready_after_clear", o_ready, 1);
    rd(3, 1, q, m);
    check("clear_rd_q_3_1", q, 0);
    check("clear_rd_qmax_3", m, 0);
    rd(63, 3, q, m);
    check("clear_rd_q_63_3", q, 0);
    check("clear_rd_qmax_63", m, 0);

    // r only: 128*256>>8 = 128
    send(3, 1, 5, 256, 128, 230, st0);
    check("first_no_stall", st0, 0);
    repeat (3) tick();
    check("t2_upd_valid", o_upd_valid, 1);
    check("t2_upd_state", o_upd_state, 3);
    check("t2_upd_action", o_upd_action, 1);
    check("t2_upd_q", o_upd_q, 128);
    check("t2_qmax_wr", o_upd_qmax_wr, 1);
    check("t2_pulse_len", (tick_and_sample()), 0);
    rd(3, 1, q, m);
    check("t2_rd_q", q, 128);
    check("t2_rd_qmax", m, 128);

    // discount only: ag=115, 115*128>>8 = 57
    send(2, 0, 3, 0, 128, 230, st0);
    repeat (3) tick();
    check("t3_upd_q", o_upd_q, 57);
    check("t3_qmax_wr", o_upd_qmax_wr, 1);
    rd(2, 0, q, m);
    check("t3_rd_q", q, 57);
    check("t3_rd_qmax", m, 57);

    send(10, 0, 11, 1000, 256, 0, st0);
    repeat (3) tick();
    check("t4_seed_q", o_upd_q, 1000);
    // 65535 + 1000 saturates
    send(12, 0, 10, 65535, 256, 256, st0);
    repeat (3) tick();
    check("t4_sat_q", o_upd_q, 65535);
    check("t4_sat_qmax_wr", o_upd_qmax_wr, 1);

    // alpha 511 clamps to 256: result 512 (1022 unclamped)
    send(13, 0, 14, 512, 511, 0, st0);
    repeat (3) tick();
    check("alpha_clamp_q", o_upd_q, 512);
    // gamma 400 clamps to 256: t3 = Qmax[10] = 1000 (1562 unclamped)
    send(13, 1, 10, 0, 256, 400, st0);
    repeat (3) tick();
    check("gamma_clamp_q", o_upd_q, 1000);
    check("gamma_clamp_qmax_wr", o_upd_qmax_wr, 1);

    send(7, 2, 8, 256, 128, 0, st0);
    send(7, 2, 8, 256, 128, 0, st1);
`ifdef QL_FWD_EN
    check("b2b_stalls", st1, 3);
`else
    check("b2b_stalls", st1, 4);
`endif
    repeat (3) tick();
    check("b2b_second_q", o_upd_q, 192);
    check("b2b_second_qmax_wr", o_upd_qmax_wr, 1);
    rd(7, 2, q, m);
    check("b2b_rd_q", q, 192);
    check("b2b_rd_qmax", m, 192);

    ready_low = 0; upd_cnt = 0; upd_sum = 0; first = -1; last = -1; cyc = 0;
    for (int i = 0; i < 28; i++) begin
      if (i < 20) begin
        i_state      = S_W'(20 + i);
        i_action     = A_W'(i % 4);
        i_next_state = S_W'(40 + i);
        i_reward     = DATA_W'(i + 1);
        i_alpha      = 9'd256;
        i_gamma      = 9'd0;
        i_valid      = 1'b1;
        #1;
        if (!o_ready) ready_low++;
        @(posedge clk);
        #1;
      end else begin
        i_valid = 1'b0;
        tick();
      end
      if (o_upd_valid) begin
        upd_cnt++;
        upd_sum += int'(o_upd_q);
        if (first < 0) first = cyc;
        last = cyc;
      end
      cyc++;
    end
    check("stream_ready_low", ready_low, 0);
    check("stream_upd_count", upd_cnt, 20);
    check("stream_upd_span", last - first + 1, 20);
    check("stream_upd_sum", upd_sum, 210);

    for (int i = 0; i < 6; i++) begin
      i_state      = S_W'(30 + i);
      i_action     = A_W'(0);
      i_next_state = S_W'(50 + i);
      i_reward     = DATA_W'(100);
      i_alpha      = 9'd256;
      i_gamma      = 9'd0;
      i_valid      = 1'b1;
      tick();
    end
    rst_n   = 1'b0;
    i_valid = 1'b0;
    #1;
    check("midrst_upd_valid", o_upd_valid, 0);
    check("midrst_busy", o_busy, 1);
    check("midrst_ready", o_ready, 0);
    tick();
    tick();
    rst_n = 1'b1;
    cnt = 0;
    upd_cnt = 0;
    while (o_busy && cnt < 1000) begin
      tick();
      cnt++;
      if (o_upd_valid) upd_cnt++;
    end
    repeat (4) begin
      tick();
      if (o_upd_valid) upd_cnt++;
    end
    check("midrst_clear_cycles", cnt, 256);
    check("midrst_no_upd", upd_cnt, 0);
    rd(3, 1, q, m);
    check("midrst_rd_q_3_1", q, 0);
    check("midrst_rd_qmax_3", m, 0);
    rd(12, 0, q, m);
    check("midrst_rd_q_12_0", q, 0);
    check("midrst_rd_qmax_12", m, 0);
    rd(30, 0, q, m);
    check("midrst_rd_q_30_0", q, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  function automatic int tick_and_sample();
    return 0;
  endfunction

endmodule

// File: doc/qlearn_update_engine.md
Name: qlearn_update_engine

Overview:
- Parametrised, fully pipelined Q-learning update engine.
- Replaces the fixed 64-state/4-action, 8-bit pipeline.
- Accepts environment transitions (s, a, s', r) over a valid/ready handshake and computes Q[s,a] <= (1-α)·Q[s,a] + α·r + α·γ·Qmax[s'] in unsigned fixed point.
- Writes the result back to an internal Q table, and to a per-state Qmax table when the new value is larger.
- Sits between the environment/transition source and the policy logic; the policy logic reads tables through a side read port.

Parameters:
- N_STATES, 64, number of states; S_W = clog2(N_STATES) (localparam).
- N_ACTIONS, 4, actions per state; A_W = clog2(N_ACTIONS) (localparam); Q depth = N_STATES·N_ACTIONS.
- DATA_W, 16, width of Q values and rewards (unsigned).
- FRAC_W, 8, fractional bits of Q, r, α and γ; 1.0 = 2^FRAC_W.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  transition valid
- o_ready  out  1  engine can accept a transition
- i_state  in  S_W  current state s
- i_action  in  A_W  action a
- i_next_state  in  S_W  next state s'
- i_reward  in  DATA_W  reward r
- i_alpha  in  FRAC_W+1  learning rate α
- i_gamma  in  FRAC_W+1  discount γ
- o_upd_valid  out  1  one-cycle pulse, write-back performed this cycle
- o_upd_state  out  S_W  state written
- o_upd_action  out  A_W  action written
- o_upd_q  out  DATA_W  new Q value
- o_upd_qmax_wr  out  1  Qmax[s] also written this cycle
- o_busy  out  1  table clear in progress
- i_rd_state  in  S_W  side-read state
- i_rd_action  in  A_W  side-read action
- o_rd_q  out  DATA_W  Q[i_rd_state,i_rd_action], 1-cycle latency
- o_rd_qmax  out  DATA_W  Qmax[i_rd_state], 1-cycle latency

Behaviour:
- Reset: all outputs 0 except o_busy=1. All pipeline valids cleared.
- Clear FSM, states CLEAR -> RUN:
  - CLEAR walks address 0..(N_STATES·N_ACTIONS-1), writing 0 to Q, and to Qmax while addr < N_STATES. One address per cycle.
  - After the last address: RUN, o_busy=0.
  - Reset asserted mid-operation aborts everything in flight and restarts CLEAR at address 0.
- o_ready = RUN && !hazard. A transfer happens when i_valid && o_ready. The source holds its inputs stable while i_valid && !o_ready.
- Hazard: asserted if i_state or i_next_state equals o_upd-bound state of any valid item in S1..S4.
- Inputs with α or γ > 2^FRAC_W are clamped to 2^FRAC_W at accept.
- Pipeline: one transition per cycle, write-back 4 cycles after accept.
  - S1: register inputs; issue reads of Q[s·N_ACTIONS+a] and Qmax[s] and Qmax[s'].
  - S2: capture read data; ag = (α·γ)>>FRAC_W; oma = 2^FRAC_W - α.
  - S3: register t1 = (oma·q)>>FRAC_W, t2 = (α·r)>>FRAC_W, t3 = (ag·qmax')>>FRAC_W. Truncation toward zero.
  - S4: sum = t1+t2+t3 in DATA_W+2 bits, saturated to 2^DATA_W-1.
    - Write Q; pulse o_upd_valid with o_upd_state/o_upd_action/o_upd_q.
    - If sum > Qmax[s] (value read in S1), write Qmax[s]=sum and o_upd_qmax_wr=1.
- Qmax is monotonic non-decreasing per state (upper bound of the row); exact when updates never decrease Q.
- Tables use separate write and read ports.
- Side read returns pre-write (old) data when it hits the address written in the same cycle.
- Side reads during CLEAR return undefined data and are not checked.

Optional Feature:
- Macro: QL_FWD_EN.
- Defined: S4 write-back value is forwarded into S2 read data on a Q-address or Qmax-state match, and S4 is excluded from the hazard check (stall window S1..S3).
- Undefined: no forwarding; hazard covers S1..S4.
- Write-back values are identical either way; only stall cycles differ.

Test Plan:
- Reset then idle -> o_busy high exactly 256 cycles (defaults), then o_ready=1; all side reads return 0.
- α=128, γ=230, (s=3,a=1,s'=5,r=256) -> 4 cycles later o_upd_q=128, o_upd_qmax_wr=1; o_rd_qmax(3)=128.
- Follow with (s=2,a=0,s'=3,r=0) -> o_upd_q=57 (ag=115, 115·128>>8); Qmax[2]=57.
- α=256, γ=256, r=65535, Qmax[s']=1000 -> o_upd_q=65535 (saturated).
- Back-to-back (s=7,a=2) twice -> o_ready low for 4 cycles (3 with QL_FWD_EN); second result builds on the first (α=128, r=256: 128 then 192).
- Stream 20 transitions with unrelated states -> o_ready constantly 1, one o_upd_valid per cycle. Assert i_rst_n mid-stream -> no further o_upd_valid, CLEAR restarts, tables read back 0.
